// File: rtl/flash_op_sequencer.sv
// Flash operation sequencer: turns one decoded flash command into the chain of
// single-byte-opcode transactions it needs. The chain is an optional WREN or RSTEN
// prefix, the main op, then RDSR busy polling or a fixed settle delay.
module flash_op_sequencer #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned LEN_W     = 4,
   parameter int unsigned POLL_GAP  = 16,
   parameter int unsigned MAX_POLLS = 1024,
   parameter int unsigned RST_WAIT  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              txn_valid,
   input  logic              txn_ready,
   output logic [7:0]        txn_opcode,
   output logic [ADDR_W-1:0] txn_addr,
   output logic [LEN_W-1:0]  txn_len,
   input  logic              txn_done,
   input  logic [7:0]        txn_status,
   output logic              busy,
   output logic              op_done,
   output logic              op_err,
   output logic [1:0]        err_code
);

   localparam int unsigned PollW   = $clog2(MAX_POLLS) + 1;
   localparam int unsigned WaitMax = (POLL_GAP > RST_WAIT) ? POLL_GAP : RST_WAIT;
   localparam int unsigned WaitW   = $clog2(WaitMax + 1);

   localparam logic [7:0] OpRead  = 8'h03;
   localparam logic [7:0] OpProg  = 8'h02;
   localparam logic [7:0] OpSe    = 8'h20;
   localparam logic [7:0] OpBe32  = 8'h52;
   localparam logic [7:0] OpBe64  = 8'hD8;
   localparam logic [7:0] OpRst   = 8'h99;
   localparam logic [7:0] OpRsten = 8'h66;
   localparam logic [7:0] OpWren  = 8'h06;
   localparam logic [7:0] OpRdsr  = 8'h05;

   typedef enum logic [3:0] {
      StIdle, StPreReq, StPreWait, StOpReq, StOpWait,
      StGap, StPollReq, StPollWait, StSettle, StFin
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              op_err_q, op_err_d;
   logic              wip;

   // Only WIP matters; the remaining status bits are deliberately don't-care.
   assign wip = txn_status[0] | (1'b0 & (^txn_status[7:1]));

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign op_done   = (state_q == StFin);
   assign op_err    = op_err_q;
   assign err_code  = err_code_q;

   // State and captured-command registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         poll_cnt_q <= '0;
         wait_cnt_q <= '0;
         err_code_q <= 2'b00;
         op_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         poll_cnt_q <= poll_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         err_code_q <= err_code_d;
         op_err_q   <= op_err_d;
      end
   end

   // Next-state logic: walk the transaction chain for the captured opcode.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      len_d      = len_q;
      poll_cnt_d = poll_cnt_q;
      wait_cnt_d = wait_cnt_q;
      err_code_d = err_code_q;
      op_err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d       = cmd_opcode;
               addr_d     = cmd_addr;
               len_d      = cmd_len;
               err_code_d = 2'b00;
               poll_cnt_d = '0;
               wait_cnt_d = '0;
               case (cmd_opcode)
                  OpRead:                               state_d = StOpReq;
                  OpProg, OpSe, OpBe32, OpBe64, OpRst:  state_d = StPreReq;
                  default: begin
                     op_err_d   = 1'b1;
                     err_code_d = 2'b01;
                  end
               endcase
            end
         end
         StPreReq:  if (txn_ready) state_d = StPreWait;
         StPreWait: if (txn_done)  state_d = StOpReq;
         StOpReq:   if (txn_ready) state_d = StOpWait;
         StOpWait: begin
            if (txn_done) begin
               wait_cnt_d = '0;
               poll_cnt_d = '0;
               case (op_q)
                  OpRead:  state_d = StFin;
                  OpRst:   state_d = StSettle;
                  default: state_d = StGap;
               endcase
            end
         end
         StGap: begin
            if (wait_cnt_q == WaitW'(POLL_GAP - 1)) begin
               wait_cnt_d = '0;
               state_d    = StPollReq;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
         StPollReq: if (txn_ready) state_d = StPollWait;
         StPollWait: begin
            if (txn_done) begin
               if (!wip) begin
                  state_d = StFin;
               end else if ((poll_cnt_q + PollW'(1)) == PollW'(MAX_POLLS)) begin
                  state_d    = StIdle;
                  op_err_d   = 1'b1;
                  err_code_d = 2'b10;
               end else begin
                  poll_cnt_d = poll_cnt_q + PollW'(1);
                  wait_cnt_d = '0;
                  state_d    = StGap;
               end
            end
         end
         StSettle: begin
            if (wait_cnt_q == WaitW'(RST_WAIT - 1)) begin
               wait_cnt_d = '0;
               state_d    = StFin;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Transaction request fields, decoded from state so they hold steady while waiting.
   always_comb begin
      txn_valid  = 1'b0;
      txn_opcode = 8'h00;
      txn_addr   = '0;
      txn_len    = '0;
      case (state_q)
         StPreReq: begin
            txn_valid  = 1'b1;
            txn_opcode = (op_q == OpRst) ? OpRsten : OpWren;
         end
         StOpReq: begin
            txn_valid  = 1'b1;
            txn_opcode = op_q;
            txn_addr   = (op_q == OpRst) ? '0 : addr_q;
            txn_len    = ((op_q == OpRead) || (op_q == OpProg)) ? len_q : '0;
         end
         StPollReq: begin
            txn_valid  = 1'b1;
            txn_opcode = OpRdsr;
            txn_len    = LEN_W'(1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Self-checking bench for flash_op_sequencer: a randomised flash-FSM responder
// plus a reference model that lists the transactions each command should produce.
module tb_flash_op_sequencer;

   localparam int unsigned ADDR_W    = 24;
   localparam int unsigned LEN_W     = 4;
   localparam int unsigned POLL_GAP  = 16;
   localparam int unsigned MAX_POLLS = 4;
   localparam int unsigned RST_WAIT  = 64;
   localparam int          BOUND     = 3000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready;
   logic [7:0]        cmd_opcode;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              txn_valid, txn_ready;
   logic [7:0]        txn_opcode;
   logic [ADDR_W-1:0] txn_addr;
   logic [LEN_W-1:0]  txn_len;
   logic              txn_done;
   logic [7:0]        txn_status;
   logic              busy, op_done, op_err;
   logic [1:0]        err_code;

   flash_op_sequencer #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .POLL_GAP(POLL_GAP),
      .MAX_POLLS(MAX_POLLS), .RST_WAIT(RST_WAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_opcode(txn_opcode),
      .txn_addr(txn_addr), .txn_len(txn_len), .txn_done(txn_done), .txn_status(txn_status),
      .busy(busy), .op_done(op_done), .op_err(op_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      int                rise;
      int                prev_done;
   } txn_t;

   txn_t       log_q[$];
   txn_t       exp_q[$];
   logic [7:0] stat_q[$];
   logic [7:0] cur_stats [MAX_POLLS];

   int total = 0, bad = 0;
   int fixed_lat = 0;
   bit spur_en = 1'b0;
   int last_done_cyc = 0;
   int accepts = 0, n_done = 0, n_err = 0, n_both = 0, n_unstable = 0;
   int accept_cyc = 0, done_cyc = 0, err_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Flash-FSM stand-in: random ready delay and completion latency, optional stray done pulses.
   initial begin : responder
      int lat;
      int rdy_dly;
      bit is_poll;
      lat = 0; rdy_dly = 0; is_poll = 1'b0;
      txn_ready = 1'b0; txn_done = 1'b0; txn_status = 8'h00;
      forever begin
         @(negedge clk);
         txn_done = 1'b0;
         if (!rst_n) begin
            txn_ready = 1'b0; lat = 0; rdy_dly = 0;
         end else if (txn_ready) begin
            txn_ready = 1'b0;
            lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
         end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
               txn_done = 1'b1;
               last_done_cyc = cyc;
               if (is_poll && stat_q.size() > 0) txn_status = stat_q.pop_front();
               else txn_status = 8'($urandom) | 8'h01;
            end
         end else if (txn_valid) begin
            if (rdy_dly == 0) begin
               txn_ready = 1'b1;
               is_poll = (txn_opcode == 8'h05);
               rdy_dly = $urandom_range(0, 2);
            end else begin
               rdy_dly--;
            end
         end else if (spur_en && $urandom_range(0, 5) == 0) begin
            txn_done = 1'b1;
            txn_status = 8'h00;
         end
      end
   end

   // Observer: logs accepted transactions, handshakes, pulses and timing.
   initial begin : monitor
      bit   prev_valid;
      txn_t first;
      txn_t t;
      prev_valid = 1'b0;
      first = '{op: 8'h00, addr: '0, len: '0, rise: 0, prev_done: 0};
      forever begin
         @(negedge clk); #1;
         if (cmd_valid && cmd_ready) begin accepts++; accept_cyc = cyc; end
         if (txn_valid && !prev_valid) begin
            first.op = txn_opcode; first.addr = txn_addr; first.len = txn_len;
            first.rise = cyc; first.prev_done = last_done_cyc;
         end
         if (txn_valid && (txn_opcode !== first.op || txn_addr !== first.addr ||
                           txn_len !== first.len)) n_unstable++;
         if (txn_valid && txn_ready) begin
            t = first;
            log_q.push_back(t);
         end
         prev_valid = txn_valid;
         if (op_done) begin n_done++; done_cyc = cyc; end
         if (op_err) begin n_err++; err_cyc = cyc; end
         if (op_done && op_err) n_both++;
      end
   end

   task automatic push_exp(input logic [7:0] op, input logic [ADDR_W-1:0] a,
                           input logic [LEN_W-1:0] l);
      txn_t t;
      t.op = op; t.addr = a; t.len = l; t.rise = 0; t.prev_done = 0;
      exp_q.push_back(t);
   endtask

   // Issue one command, predict its transaction list and outcome, then compare.
   task automatic run_cmd(input logic [7:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input bit hold, input string tag);
      bit         e_ok;
      logic [1:0] e_code;
      bit         got;
      bit         fin;
      int         gap;
      e_ok = 1'b1; e_code = 2'b00;
      exp_q.delete();
      case (op)
         8'h03: push_exp(op, addr, len);
         8'h99: begin push_exp(8'h66, '0, '0); push_exp(8'h99, '0, '0); end
         8'h02, 8'h20, 8'h52, 8'hD8: begin
            push_exp(8'h06, '0, '0);
            push_exp(op, addr, (op == 8'h02) ? len : '0);
            for (int i = 0; i < MAX_POLLS; i++) begin
               push_exp(8'h05, '0, LEN_W'(1));
               if (!cur_stats[i][0]) break;
               if (i == MAX_POLLS - 1) begin e_ok = 1'b0; e_code = 2'b10; end
            end
         end
         default: begin e_ok = 1'b0; e_code = 2'b01; end
      endcase
      stat_q.delete();
      for (int i = 0; i < MAX_POLLS; i++) stat_q.push_back(cur_stats[i]);
      log_q.delete();
      accepts = 0; n_done = 0; n_err = 0; n_both = 0; n_unstable = 0;

      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = addr; cmd_len = len;
      got = 1'b0;
      for (int k = 0; k < BOUND && !got; k++) begin
         @(negedge clk);
         if (accepts > 0) got = 1'b1;
      end
      chk({tag, " accepted"}, 32'(got), 32'd1);
      if (!hold) cmd_valid = 1'b0;
      fin = 1'b0;
      for (int k = 0; k < BOUND && !fin; k++) begin
         @(negedge clk); #2;
         if (n_done + n_err > 0) fin = 1'b1;
      end
      chk({tag, " finished"}, 32'(fin), 32'd1);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      chk({tag, " accept count"}, 32'(accepts), 32'd1);
      chk({tag, " op_done count"}, 32'(n_done), 32'(e_ok));
      chk({tag, " op_err count"}, 32'(n_err), 32'(!e_ok));
      chk({tag, " done&err overlap"}, 32'(n_both), 32'd0);
      chk({tag, " txn field stability"}, 32'(n_unstable), 32'd0);
      chk({tag, " err_code"}, 32'(err_code), 32'(e_code));
      chk({tag, " idle after"}, {busy, cmd_ready}, 32'b01);
      chk({tag, " txn count"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < log_q.size()) begin
            chk($sformatf("%s txn%0d fields", tag, i),
                {log_q[i].op, log_q[i].addr}, {exp_q[i].op, exp_q[i].addr});
            chk($sformatf("%s txn%0d len", tag, i), 32'(log_q[i].len), 32'(exp_q[i].len));
            if (i == 0) gap = log_q[i].rise - accept_cyc;
            else gap = log_q[i].rise - log_q[i].prev_done;
            chk($sformatf("%s txn%0d issue delay", tag, i), 32'(gap),
                (i == 0) ? 32'd1 : (exp_q[i].op == 8'h05) ? 32'(POLL_GAP + 1) : 32'd1);
         end
      end
      if (e_ok)
         chk({tag, " op_done latency"}, 32'(done_cyc - last_done_cyc),
             (op == 8'h99) ? 32'(RST_WAIT + 1) : 32'd1);
      else if (e_code == 2'b10)
         chk({tag, " timeout err latency"}, 32'(err_cyc - last_done_cyc), 32'd1);
      else
         chk({tag, " bad opcode err latency"}, 32'(err_cyc - accept_cyc), 32'd1);
   endtask

   initial begin : main
      logic [7:0] op;
      int         sel;
      int         k;
      bit         hold;
      bit         seen;
      cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_addr = '0; cmd_len = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {cmd_ready, busy, txn_valid, op_done, op_err, err_code}, 32'b1000000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after release idle", {cmd_ready, busy, txn_valid}, 32'b100);

      // Read with fixed 5-cycle completion.
      fixed_lat = 5;
      for (int i = 0; i < MAX_POLLS; i++) cur_stats[i] = 8'h00;
      run_cmd(8'h03, 24'h001000, 4'd4, 1'b0, "read");
      fixed_lat = 0;

      // Program: two busy polls then WIP clear.
      cur_stats[0] = 8'h03; cur_stats[1] = 8'h03; cur_stats[2] = 8'h00; cur_stats[3] = 8'h01;
      run_cmd(8'h02, 24'h000100, 4'd8, 1'b0, "program");

      // Sector erase that never finishes: poll timeout.
      for (int i = 0; i < MAX_POLLS; i++) cur_stats[i] = 8'h01;
      run_cmd(8'h20, 24'h00A000, 4'd3, 1'b0, "erase timeout");

      // Software reset sequence with settle delay.
      run_cmd(8'h99, 24'h123456, 4'd7, 1'b0, "reset op");

      // Unsupported opcode; error code must persist while idle.
      run_cmd(8'h55, 24'h000010, 4'd1, 1'b0, "bad opcode");
      repeat (10) @(negedge clk);
      chk("err_code held while idle", 32'(err_code), 32'd1);

      // Command held valid for the whole operation: only one accept.
      for (int i = 0; i < MAX_POLLS; i++) cur_stats[i] = 8'h00;
      run_cmd(8'h52, 24'h040000, 4'd2, 1'b1, "held 52");

      // Asynchronous reset while waiting on an RDSR poll.
      for (int i = 0; i < MAX_POLLS; i++) cur_stats[i] = 8'h01;
      stat_q.delete();
      for (int i = 0; i < MAX_POLLS; i++) stat_q.push_back(8'h01);
      fixed_lat = 20;
      log_q.delete(); n_done = 0; n_err = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 8'h02; cmd_addr = 24'h000200; cmd_len = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < BOUND && !seen; j++) begin
         @(negedge clk); #2;
         if (log_q.size() >= 3) seen = 1'b1;
      end
      chk("abort reached poll", 32'(seen), 32'd1);
      @(negedge clk); #3;
      chk("abort busy before reset", {busy, txn_valid}, 32'b10);
      rst_n = 1'b0;
      #1;
      chk("abort async outputs", {txn_valid, busy, cmd_ready}, 32'b001);
      repeat (3) @(negedge clk);
      chk("abort no pulses", 32'(n_done + n_err), 32'd0);
      chk("abort err_code", 32'(err_code), 32'd0);
      rst_n = 1'b1;
      fixed_lat = 0;
      stat_q.delete();
      for (int i = 0; i < MAX_POLLS; i++) cur_stats[i] = 8'h00;
      run_cmd(8'h03, 24'hABCDEF, 4'd9, 1'b0, "read after abort");

      // Randomised commands with stray done pulses outside wait states.
      spur_en = 1'b1;
      for (int r = 0; r < 12; r++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0: op = 8'h03;
            1: op = 8'h02;
            2: op = 8'h20;
            3: op = 8'h52;
            4: op = 8'hD8;
            5: op = 8'h99;
            default: begin
               op = 8'($urandom);
               while (op inside {8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99}) op = op + 8'd1;
            end
         endcase
         k = $urandom_range(0, MAX_POLLS);
         for (int i = 0; i < MAX_POLLS; i++)
            cur_stats[i] = (8'($urandom) & 8'hFE) | ((i < k) ? 8'h01 : 8'h00);
         hold = ($urandom_range(0, 1) == 1) && (sel < 6) &&
                ((k < MAX_POLLS) || (sel == 0) || (sel == 5));
         run_cmd(op, ADDR_W'($urandom), LEN_W'($urandom), hold, $sformatf("rnd%0d", r));
      end
      spur_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
